// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared FSM state, stall/flush bundle and RUN-state hazard priority
package hazard_definitions;

    typedef enum logic [1:0] {
        HZ_INIT     = 2'd0,
        HZ_RUN      = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_CTRL_IDLE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t HZ_CTRL_PURGE    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam hz_ctrl_t HZ_CTRL_MEM_HOLD = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Redirect squashes the younger instructions, so neither load-use nor fetch miss matters then.
    function automatic hz_ctrl_t hz_run_ctrl(input logic redirect,
                                             input logic load_use,
                                             input logic imem_ready);
        hz_ctrl_t c;
        c = HZ_CTRL_IDLE;
        if (redirect) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else begin
            if (load_use) begin
                c.pc_stall    = 1'b1;
                c.if_id_stall = 1'b1;
                c.id_ex_flush = 1'b1;
            end
            if (!imem_ready) begin
                c.pc_stall    = 1'b1;
                c.if_id_flush = 1'b1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// rtl/hazard_ctrl_perf_cnt.sv - free-running stall-cycle and redirect-flush event counters
module hazard_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stall,
    input  logic              i_flush_evt,
    output logic [PERF_W-1:0] o_stall_cyc,
    output logic [PERF_W-1:0] o_flush_cnt
);

    logic [PERF_W-1:0] r_stall_cyc;
    logic [PERF_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cyc <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall)     r_stall_cyc <= r_stall_cyc + PERF_W'(1);
            if (i_flush_evt) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
        end
    end

    assign o_stall_cyc = r_stall_cyc;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller; HAZARD_PERF_CNT_EN adds perf counters
module hazard_ctrl
    import hazard_definitions::*;
#(
    parameter int INIT_FLUSH_CYCLES = 2,
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int PERF_W            = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_MemRead,
    input  logic              ex_redirect,
    input  logic              imem_ready,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              mem_wb_flush,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] perf_stall_cyc,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    localparam int INIT_W = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYCLES - 1);

    hz_state_t         r_state;
    hz_state_t         w_next_state;
    logic [INIT_W-1:0] r_init_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;
    hz_ctrl_t          w_ctrl;
    hz_ctrl_t          w_run_ctrl;
    logic              w_load_use;
    logic              w_mem_hold;

    assign w_load_use = ex_MemRead && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_mem_hold = mem_req && !mem_ready;
    assign w_run_ctrl = hz_run_ctrl(ex_redirect, w_load_use, imem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= HZ_INIT;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HZ_INIT:     if (r_init_cnt == '0) w_next_state = HZ_RUN;
            HZ_RUN:      if (w_mem_hold)       w_next_state = HZ_MEM_WAIT;
            HZ_MEM_WAIT: if (mem_ready)        w_next_state = HZ_RUN;
            default:                           w_next_state = HZ_INIT;
        endcase
    end

    // Once waiting, only mem_ready releases the freeze; mem_req is not re-examined.
    always_comb begin
        w_ctrl = HZ_CTRL_PURGE;
        case (r_state)
            HZ_INIT:     w_ctrl = HZ_CTRL_PURGE;
            HZ_RUN:      w_ctrl = w_mem_hold ? HZ_CTRL_MEM_HOLD : w_run_ctrl;
            HZ_MEM_WAIT: w_ctrl = mem_ready  ? w_run_ctrl : HZ_CTRL_MEM_HOLD;
            default:     w_ctrl = HZ_CTRL_PURGE;
        endcase
    end

    // The RUN cycle that first sees the miss is wait cycle 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt    <= INIT_LOAD;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                HZ_INIT: begin
                    if (r_init_cnt != '0) r_init_cnt <= r_init_cnt - INIT_W'(1);
                end
                HZ_RUN: begin
                    if (w_mem_hold) r_wait_cnt <= WAIT_W'(1);
                end
                HZ_MEM_WAIT: begin
                    if (mem_ready) begin
                        r_wait_cnt <= '0;
                    end else begin
                        if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        if (r_wait_cnt == WAIT_MAX) r_mem_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_stall     = w_ctrl.pc_stall;
    assign if_id_stall  = w_ctrl.if_id_stall;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_stall  = w_ctrl.id_ex_stall;
    assign id_ex_flush  = w_ctrl.id_ex_flush;
    assign ex_mem_stall = w_ctrl.ex_mem_stall;
    assign mem_wb_flush = w_ctrl.mem_wb_flush;
    assign mem_timeout  = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic w_flush_evt;
    assign w_flush_evt = (r_state == HZ_RUN) && ex_redirect;

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall     (w_ctrl.pc_stall),
        .i_flush_evt (w_flush_evt),
        .o_stall_cyc (perf_stall_cyc),
        .o_flush_cnt (perf_flush_cnt)
    );
`else
    assign perf_stall_cyc = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench: vector table, corner sequences, random vs reference model
module tb_hazard_ctrl;

    localparam int INIT_N = 2;
    localparam int TMO_N  = 4;
    localparam int PW     = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_PURGE = 7'b1010101;
    localparam logic [6:0] C_HOLD  = 7'b1101011;
    localparam logic [6:0] C_REDIR = 7'b0010100;
    localparam logic [6:0] C_LU    = 7'b1100100;
    localparam logic [6:0] C_MISS  = 7'b1010000;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       memrd;
        logic       redir;
        logic       imem;
        logic       mreq;
        logic       mrdy;
    } stim_t;

    typedef struct {
        stim_t      stim;
        logic [6:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex_MemRead = 0, ex_redirect = 0;
    logic imem_ready = 1, mem_req = 0, mem_ready = 0;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic mem_timeout;
    logic [PW-1:0] perf_stall_cyc, perf_flush_cnt;
    logic [6:0] act;

    int checks = 0;
    int failures = 0;

    int         m_purge_left;
    bit         m_waiting;
    int         m_wait_len;
    bit         m_timeout;
    logic [PW-1:0] m_stall_cyc;
    logic [PW-1:0] m_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.INIT_FLUSH_CYCLES(INIT_N), .TIMEOUT_CYCLES(TMO_N), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect),
        .imem_ready(imem_ready), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
        .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
    );

    assign act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, a, e, $time);
        end
    endtask

    function automatic stim_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                 input int rd, input bit mr, input bit rdr, input bit im,
                                 input bit mq, input bit my);
        stim_t s;
        s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.use1 = u1; s.use2 = u2; s.rd = 5'(rd);
        s.memrd = mr; s.redir = rdr; s.imem = im; s.mreq = mq; s.mrdy = my;
        return s;
    endfunction

    function automatic bit model_hold(input stim_t v);
        return m_waiting ? !v.mrdy : (v.mreq && !v.mrdy);
    endfunction

    function automatic logic [6:0] model_ctrl(input stim_t v);
        logic [6:0] r;
        bit lu;
        if (m_purge_left > 0) return C_PURGE;
        if (model_hold(v)) return C_HOLD;
        if (v.redir) return C_REDIR;
        lu = v.memrd && (v.rd != 0) && ((v.use1 && v.rs1 == v.rd) || (v.use2 && v.rs2 == v.rd));
        r = C_IDLE;
        if (lu) r = r | C_LU;
        if (!v.imem) r = r | C_MISS;
        return r;
    endfunction

    task automatic model_reset();
        m_purge_left = INIT_N;
        m_waiting    = 0;
        m_wait_len   = 0;
        m_timeout    = 0;
        m_stall_cyc  = '0;
        m_flush_cnt  = '0;
    endtask

    task automatic model_update(input stim_t v, input logic [6:0] e);
        bit in_run;
        in_run = (m_purge_left == 0) && !m_waiting;
        if (PERF_EN) begin
            if (e[6]) m_stall_cyc = m_stall_cyc + 1;
            if (in_run && v.redir) m_flush_cnt = m_flush_cnt + 1;
        end
        if (m_purge_left > 0) begin
            m_purge_left--;
        end else if (model_hold(v)) begin
            m_waiting = 1;
            m_wait_len++;
            if (m_wait_len >= TMO_N) m_timeout = 1;
        end else begin
            m_waiting  = 0;
            m_wait_len = 0;
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input stim_t v, output logic [6:0] seen);
        logic [6:0] e;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        ex_rd = v.rd; ex_MemRead = v.memrd; ex_redirect = v.redir;
        imem_ready = v.imem; mem_req = v.mreq; mem_ready = v.mrdy;
        #1;
        e = model_ctrl(v);
        seen = act;
        chk("ctrl_vs_model", 64'(act), 64'(e));
        chk("timeout_vs_model", 64'(mem_timeout), 64'(m_timeout));
        chk("perf_stall_vs_model", 64'(perf_stall_cyc), 64'(m_stall_cyc));
        chk("perf_flush_vs_model", 64'(perf_flush_cnt), 64'(m_flush_cnt));
        @(posedge clk);
        model_update(v, e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("reset_ctrl", 64'(act), 64'(C_PURGE));
        chk("reset_timeout", 64'(mem_timeout), 64'd0);
        chk("reset_perf_stall", 64'(perf_stall_cyc), 64'd0);
        chk("reset_perf_flush", 64'(perf_flush_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t  tab [10];
    stim_t idle, miss, redir, mwait, mdone;
    logic [6:0] s;

    initial begin
        tab[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_IDLE,  "vec_idle"};
        tab[1] = '{mk(1, 5, 0, 1, 5, 1, 0, 1, 0, 0), C_LU,    "vec_loaduse_rs2"};
        tab[2] = '{mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 0), C_IDLE,  "vec_loaduse_x0"};
        tab[3] = '{mk(1, 5, 0, 1, 5, 1, 1, 1, 0, 0), C_REDIR, "vec_redir_over_lu"};
        tab[4] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_MISS,  "vec_imem_miss"};
        tab[5] = '{mk(7, 2, 1, 0, 7, 1, 0, 0, 0, 0), 7'b1110100, "vec_lu_plus_miss"};
        tab[6] = '{mk(7, 2, 0, 1, 7, 1, 0, 1, 0, 0), C_IDLE,  "vec_rs1_unused"};
        tab[7] = '{mk(3, 3, 1, 1, 3, 0, 0, 1, 0, 0), C_IDLE,  "vec_not_load"};
        tab[8] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), C_IDLE,  "vec_mem_same_cycle"};
        tab[9] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_REDIR, "vec_redir_over_miss"};
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        miss  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        redir = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        mwait = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        mdone = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);

        @(negedge clk);
        do_reset();
        for (int i = 0; i < INIT_N; i++) begin
            step(idle, s);
            chk("purge_pc_stall", 64'(s[6]), 64'd1);
        end
        step(idle, s);
        chk("post_purge_idle", 64'(s), 64'(C_IDLE));

        for (int i = 0; i < 10; i++) begin
            step(tab[i].stim, s);
            chk(tab[i].name, 64'(s), 64'(tab[i].exp));
        end

        // Three wait cycles, redirect held throughout, then release.
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0), s);
            chk("memwait_hold", 64'(s), 64'(C_HOLD));
        end
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1), s);
        chk("memwait_release_redir", 64'(s), 64'(C_REDIR));
        step(idle, s);
        chk("back_in_run", 64'(s), 64'(C_IDLE));
        chk("no_timeout_3", 64'(mem_timeout), 64'd0);

        for (int i = 0; i < 3; i++) step(mwait, s);
        chk("timeout_not_yet", 64'(mem_timeout), 64'd0);
        step(mwait, s);
        chk("timeout_set", 64'(mem_timeout), 64'd1);
        step(mwait, s);
        chk("timeout_still_hold", 64'(s), 64'(C_HOLD));
        step(mdone, s);
        step(idle, s);
        chk("timeout_sticky", 64'(mem_timeout), 64'd1);

        step(mwait, s);
        step(mwait, s);
        do_reset();
        for (int i = 0; i < INIT_N; i++) begin
            step(mdone, s);
            chk("rerun_purge", 64'(s), 64'(C_PURGE));
        end

        do_reset();
        for (int i = 0; i < INIT_N; i++) step(idle, s);
        for (int i = 0; i < 3; i++) step(miss, s);
        for (int i = 0; i < 2; i++) step(redir, s);
        step(idle, s);
        chk("perf_stall_purge2_plus3", 64'(perf_stall_cyc), PERF_EN ? 64'd5 : 64'd0);
        chk("perf_flush_2", 64'(perf_flush_cnt), PERF_EN ? 64'd2 : 64'd0);

        for (int n = 0; n < 1500; n++) begin
            stim_t r;
            if ($urandom_range(0, 299) == 0) do_reset();
            r.rs1   = 5'($urandom_range(0, 3));
            r.rs2   = 5'($urandom_range(0, 3));
            r.rd    = 5'($urandom_range(0, 3));
            r.use1  = 1'($urandom_range(0, 1));
            r.use2  = 1'($urandom_range(0, 1));
            r.memrd = 1'($urandom_range(0, 1));
            r.redir = ($urandom_range(0, 5) == 0);
            r.imem  = ($urandom_range(0, 4) != 0);
            r.mreq  = ($urandom_range(0, 2) == 0);
            r.mrdy  = ($urandom_range(0, 2) != 0);
            step(r, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
